demux_vc: RTL and testbench
===========================

# demux_vc

Virtual-channel demultiplexer at the write end of the VC0/VC1 FIFO pair; it is the counterpart of the VC0/VC1 output mux, which reads those FIFOs. It accepts words from an upstream source through a valid/ready handshake and steers each word to VC0 or VC1 by its class bit. Each word is written with a registered single-cycle push. When the target FIFO is full, the word is parked in a one-entry hold register and input is stalled until the FIFO frees up.

## Interface
- DATA_SIZE, 4, word width; bit DATA_SIZE-1 is the class bit (0 = VC0, 1 = VC1)
- clk  in  1  single clock, rising edge
- reset_L  in  1  asynchronous, active-low reset
- valid_in  in  1  upstream word present
- data_in  in  DATA_SIZE  upstream word
- ready_out  out  1  block can accept a word this cycle
- full_VC0  in  1  VC0 FIFO cannot take a push next cycle
- full_VC1  in  1  VC1 FIFO cannot take a push next cycle
- push_VC0  out  1  write strobe to VC0 FIFO
- push_VC1  out  1  write strobe to VC1 FIFO
- data_VC0  out  DATA_SIZE  write data to VC0 FIFO
- data_VC1  out  DATA_SIZE  write data to VC1 FIFO
- pending  out  1  hold register occupied
- count_VC0  out  8  words pushed to VC0, wraps 255 -> 0
- count_VC1  out  8  words pushed to VC1, wraps 255 -> 0

## Operation
- Design has one clock (clk). Reset (reset_L) is asynchronous and active-low.
- FSM states:
  - INIT: reset state.
  - PASS: accepting words.
  - HOLD: word parked.
- While reset_L is 0, all outputs are 0 (ready_out, pushes, data, pending, counters). The state is INIT and the hold register is cleared.
- INIT -> PASS on the first rising edge with reset_L = 1.
- ready_out = 1 only in PASS.
- Accept = valid_in & ready_out at a rising edge. The target is data_in[DATA_SIZE-1].
- PASS, accept, target full flag = 0:
  - Next cycle, push_VCx = 1 and data_VCx = data_in.
  - State stays PASS.
- PASS, accept, target full flag = 1:
  - Word goes into the hold register. No push.
  - State -> HOLD, pending = 1.
- HOLD:
  - Each edge, check the held word's target full flag.
  - While it is 1: hold, no push.
  - When it is 0: push the held word next cycle, clear pending, state -> PASS.
- Only one of push_VC0/push_VC1 is high in any cycle. Each push is a single-cycle pulse.
- data_VCx holds its last pushed value when push_VCx = 0.
- The full flag of the non-target VC is ignored; VCs do not block each other except through the single hold register.
- valid_in while ready_out = 0 is ignored. Upstream must hold the word until it sees ready_out = 1.
- Counters: count_VCx increments on the same edge that raises push_VCx. 8-bit, modulo 256.
- Reset mid-operation: push outputs and counters go to 0 immediately and any held word is lost. Operation restarts via INIT.

## Timing
- Latency: accept at edge N (target not full) -> push_VCx/data_VCx valid during cycle N..N+1.
- Back-to-back: in PASS, one word per cycle with no bubbles, alternating VCs allowed.
- Stall: accept into HOLD at edge N.
  - ready_out = 0 from edge N.
  - If the full flag is seen low at edge M, push is high in cycle M..M+1.
  - ready_out = 1 from edge M, so the next word can be accepted at edge M+1.
- ready_out, pending, pushes, data and counters are all registered; no combinational path from inputs to outputs.
- Full flags are sampled only at the accept/hold decision edge.

## Test plan
- Reset: hold reset_L = 0 for 3 cycles with valid_in = 1 -> all outputs 0; ready_out rises after the first edge with reset_L = 1.
- Steering: stream 0x3, 0xA, 0x5, 0xC, both FIFOs not full -> VC0 gets 0x3, 0x5 and VC1 gets 0xA, 0xC. One-cycle latency, no bubbles; count_VC0 = 2, count_VC1 = 2.
- Stall: full_VC1 = 1, send 0x9 -> pending = 1, ready_out = 0, no push. Drop full_VC1 after 4 cycles -> push_VC1 with data 0x9 the next cycle, then ready_out = 1.
- Independence: full_VC0 = 1 while streaming VC1 words 0x8, 0xF -> both are pushed normally with no stall.
- Wrap: push 256 VC0 words -> count_VC0 reads 0 after the 256th push, 1 after the 257th.
- Reset mid-HOLD: park 0xB for VC1, pulse reset_L low -> pending = 0, count_VC1 = 0, and 0xB is never pushed after reset.

Source files
------------

// File: rtl/demux_vc.sv
// Steers upstream words to the VC0/VC1 FIFOs by class bit with a registered 1-cycle push.
// A word that meets a full target is parked in a single hold register, which stalls input until it drains.
module demux_vc #(
   parameter int DATA_SIZE = 4
) (
   input  logic                 clk,
   input  logic                 reset_L,
   input  logic                 valid_in,
   input  logic [DATA_SIZE-1:0] data_in,
   output logic                 ready_out,
   input  logic                 full_VC0,
   input  logic                 full_VC1,
   output logic                 push_VC0,
   output logic                 push_VC1,
   output logic [DATA_SIZE-1:0] data_VC0,
   output logic [DATA_SIZE-1:0] data_VC1,
   output logic                 pending,
   output logic [7:0]           count_VC0,
   output logic [7:0]           count_VC1
);

   typedef enum logic [1:0] {
      INIT = 2'd0,
      PASS = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t               state_q;
   logic                 ready_q;
   logic                 pend_q;
   logic [DATA_SIZE-1:0] hold_q;
   logic                 push0_q, push1_q;
   logic [DATA_SIZE-1:0] data0_q, data1_q;
   logic [7:0]           cnt0_q, cnt1_q;

   logic                 accept;
   logic                 in_blocked;
   logic                 hold_free;
   logic                 push0_d, push1_d;
   logic [DATA_SIZE-1:0] word_d;

   // Only the target VC's full flag matters; the other VC never blocks this word.
   always_comb begin
      accept     = valid_in & ready_q & (state_q == PASS);
      in_blocked = data_in[DATA_SIZE-1] ? full_VC1 : full_VC0;
      hold_free  = hold_q[DATA_SIZE-1] ? ~full_VC1 : ~full_VC0;
      push0_d    = 1'b0;
      push1_d    = 1'b0;
      word_d     = data_in;
      if (state_q == HOLD) begin
         word_d = hold_q;
         if (hold_free) begin
            push0_d = ~hold_q[DATA_SIZE-1];
            push1_d =  hold_q[DATA_SIZE-1];
         end
      end else if (accept && !in_blocked) begin
         push0_d = ~data_in[DATA_SIZE-1];
         push1_d =  data_in[DATA_SIZE-1];
      end
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state_q <= INIT;
         ready_q <= 1'b0;
         pend_q  <= 1'b0;
         hold_q  <= '0;
         push0_q <= 1'b0;
         push1_q <= 1'b0;
         data0_q <= '0;
         data1_q <= '0;
         cnt0_q  <= 8'd0;
         cnt1_q  <= 8'd0;
      end else begin
         push0_q <= push0_d;
         push1_q <= push1_d;
         if (push0_d) begin
            data0_q <= word_d;
            cnt0_q  <= cnt0_q + 8'd1;
         end
         if (push1_d) begin
            data1_q <= word_d;
            cnt1_q  <= cnt1_q + 8'd1;
         end
         case (state_q)
            INIT: begin
               state_q <= PASS;
               ready_q <= 1'b1;
            end
            PASS: begin
               if (accept && in_blocked) begin
                  hold_q  <= data_in;
                  state_q <= HOLD;
                  ready_q <= 1'b0;
                  pend_q  <= 1'b1;
               end
            end
            HOLD: begin
               // Ready returns on the drain edge so the next word lands one edge later.
               if (hold_free) begin
                  hold_q  <= '0;
                  state_q <= PASS;
                  ready_q <= 1'b1;
                  pend_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= INIT;
               ready_q <= 1'b0;
               pend_q  <= 1'b0;
            end
         endcase
      end
   end

   assign ready_out = ready_q;
   assign pending   = pend_q;
   assign push_VC0  = push0_q;
   assign push_VC1  = push1_q;
   assign data_VC0  = data0_q;
   assign data_VC1  = data1_q;
   assign count_VC0 = cnt0_q;
   assign count_VC1 = cnt1_q;

endmodule

// File: tb/tb_demux_vc.sv
// Bench for demux_vc: vector table, corner-case sequences and random traffic against a queue-based model.
module tb_demux_vc;
   localparam int DW = 4;

   logic          clk = 1'b0;
   logic          reset_L;
   logic          valid_in;
   logic [DW-1:0] data_in;
   logic          ready_out;
   logic          full_VC0, full_VC1;
   logic          push_VC0, push_VC1;
   logic [DW-1:0] data_VC0, data_VC1;
   logic          pending;
   logic [7:0]    count_VC0, count_VC1;

   always #5 clk = ~clk;

   demux_vc #(.DATA_SIZE(DW)) dut (
      .clk       (clk),
      .reset_L   (reset_L),
      .valid_in  (valid_in),
      .data_in   (data_in),
      .ready_out (ready_out),
      .full_VC0  (full_VC0),
      .full_VC1  (full_VC1),
      .push_VC0  (push_VC0),
      .push_VC1  (push_VC1),
      .data_VC0  (data_VC0),
      .data_VC1  (data_VC1),
      .pending   (pending),
      .count_VC0 (count_VC0),
      .count_VC1 (count_VC1)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference model: the hold register is a queue of at most one word.
   bit            m_started;
   logic [DW-1:0] m_held[$];
   bit            m_rdy, m_pend, m_p0, m_p1;
   logic [DW-1:0] m_d0, m_d1;
   int            m_c0, m_c1;

   function automatic void model_clear();
      m_started = 0;
      m_held.delete();
      m_rdy = 0; m_pend = 0; m_p0 = 0; m_p1 = 0;
      m_d0 = '0; m_d1 = '0; m_c0 = 0; m_c1 = 0;
   endfunction

   function automatic void deliver(input logic [DW-1:0] w);
      if (w[DW-1]) begin
         m_p1 = 1; m_d1 = w; m_c1 = (m_c1 + 1) % 256;
      end else begin
         m_p0 = 1; m_d0 = w; m_c0 = (m_c0 + 1) % 256;
      end
   endfunction

   function automatic void model_edge();
      logic [DW-1:0] w;
      bit            tgt_full;
      if (!reset_L) begin
         model_clear();
      end else begin
         m_p0 = 0; m_p1 = 0;
         if (!m_started) begin
            m_started = 1;
         end else if (m_held.size() != 0) begin
            w = m_held[0];
            tgt_full = w[DW-1] ? full_VC1 : full_VC0;
            if (!tgt_full) begin
               void'(m_held.pop_front());
               deliver(w);
            end
         end else if (valid_in) begin
            w = data_in;
            tgt_full = w[DW-1] ? full_VC1 : full_VC0;
            if (tgt_full) m_held.push_back(w);
            else          deliver(w);
         end
         m_rdy  = m_started && (m_held.size() == 0);
         m_pend = (m_held.size() != 0);
      end
   endfunction

   task automatic check_model();
      check("m_ready",   ready_out, m_rdy);
      check("m_pending", pending,   m_pend);
      check("m_push0",   push_VC0,  m_p0);
      check("m_push1",   push_VC1,  m_p1);
      check("m_data0",   data_VC0,  m_d0);
      check("m_data1",   data_VC1,  m_d1);
      check("m_count0",  count_VC0, m_c0);
      check("m_count1",  count_VC1, m_c1);
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      check_model();
   endtask

   typedef struct {
      bit         rst_n, vld, f0, f1;
      logic [3:0] dat;
      bit         e_rdy, e_pend, e_p0, e_p1;
      logic [3:0] e_d0, e_d1;
      logic [7:0] e_c0, e_c1;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input bit rst_n, vld, input logic [3:0] dat, input bit f0, f1,
                               input bit e_rdy, e_pend, e_p0, e_p1,
                               input logic [3:0] e_d0, e_d1, input logic [7:0] e_c0, e_c1);
      vec_t v;
      v.rst_n = rst_n; v.vld = vld; v.dat = dat; v.f0 = f0; v.f1 = f1;
      v.e_rdy = e_rdy; v.e_pend = e_pend; v.e_p0 = e_p0; v.e_p1 = e_p1;
      v.e_d0 = e_d0; v.e_d1 = e_d1; v.e_c0 = e_c0; v.e_c1 = e_c1;
      tbl.push_back(v);
   endfunction

   initial begin
      reset_L  = 1'b0;
      valid_in = 1'b1;
      data_in  = 4'hA;
      full_VC0 = 1'b0;
      full_VC1 = 1'b0;
      model_clear();

      //   rst vld dat  f0 f1 | rdy pnd p0 p1 d0   d1   c0 c1
      add(0, 1, 4'hA, 0, 0,   0, 0, 0, 0, 4'h0, 4'h0, 0, 0);
      add(0, 1, 4'hA, 0, 0,   0, 0, 0, 0, 4'h0, 4'h0, 0, 0);
      add(0, 1, 4'hA, 0, 0,   0, 0, 0, 0, 4'h0, 4'h0, 0, 0);
      add(1, 1, 4'h3, 0, 0,   1, 0, 0, 0, 4'h0, 4'h0, 0, 0);
      add(1, 1, 4'h3, 0, 0,   1, 0, 1, 0, 4'h3, 4'h0, 1, 0);
      add(1, 1, 4'hA, 0, 0,   1, 0, 0, 1, 4'h3, 4'hA, 1, 1);
      add(1, 1, 4'h5, 0, 0,   1, 0, 1, 0, 4'h5, 4'hA, 2, 1);
      add(1, 1, 4'hC, 0, 0,   1, 0, 0, 1, 4'h5, 4'hC, 2, 2);
      add(1, 0, 4'hC, 0, 0,   1, 0, 0, 0, 4'h5, 4'hC, 2, 2);
      add(1, 1, 4'h9, 0, 1,   0, 1, 0, 0, 4'h5, 4'hC, 2, 2);
      add(1, 1, 4'h2, 0, 1,   0, 1, 0, 0, 4'h5, 4'hC, 2, 2);
      add(1, 1, 4'h2, 0, 1,   0, 1, 0, 0, 4'h5, 4'hC, 2, 2);
      add(1, 1, 4'h2, 0, 1,   0, 1, 0, 0, 4'h5, 4'hC, 2, 2);
      add(1, 1, 4'h2, 0, 1,   0, 1, 0, 0, 4'h5, 4'hC, 2, 2);
      add(1, 1, 4'h2, 0, 0,   1, 0, 0, 1, 4'h5, 4'h9, 2, 3);
      add(1, 1, 4'h2, 0, 0,   1, 0, 1, 0, 4'h2, 4'h9, 3, 3);
      add(1, 1, 4'h8, 1, 0,   1, 0, 0, 1, 4'h2, 4'h8, 3, 4);
      add(1, 1, 4'hF, 1, 0,   1, 0, 0, 1, 4'h2, 4'hF, 3, 5);
      add(1, 0, 4'hF, 1, 0,   1, 0, 0, 0, 4'h2, 4'hF, 3, 5);

      #1;
      check("rst_ready",   ready_out, 0);
      check("rst_pending", pending,   0);
      check("rst_push0",   push_VC0,  0);
      check("rst_push1",   push_VC1,  0);
      check("rst_data0",   data_VC0,  0);
      check("rst_data1",   data_VC1,  0);
      check("rst_count0",  count_VC0, 0);
      check("rst_count1",  count_VC1, 0);

      foreach (tbl[i]) begin
         reset_L  = tbl[i].rst_n;
         valid_in = tbl[i].vld;
         data_in  = tbl[i].dat;
         full_VC0 = tbl[i].f0;
         full_VC1 = tbl[i].f1;
         step();
         check($sformatf("v%0d_ready", i),   ready_out, tbl[i].e_rdy);
         check($sformatf("v%0d_pending", i), pending,   tbl[i].e_pend);
         check($sformatf("v%0d_push0", i),   push_VC0,  tbl[i].e_p0);
         check($sformatf("v%0d_push1", i),   push_VC1,  tbl[i].e_p1);
         check($sformatf("v%0d_data0", i),   data_VC0,  tbl[i].e_d0);
         check($sformatf("v%0d_data1", i),   data_VC1,  tbl[i].e_d1);
         check($sformatf("v%0d_count0", i),  count_VC0, tbl[i].e_c0);
         check($sformatf("v%0d_count1", i),  count_VC1, tbl[i].e_c1);
      end

      // Counter wrap on VC0 after a fresh reset.
      reset_L = 1'b0; full_VC0 = 1'b0; full_VC1 = 1'b0; valid_in = 1'b0;
      step();
      reset_L = 1'b1;
      step();
      valid_in = 1'b1;
      for (int i = 0; i < 257; i++) begin
         data_in = {1'b0, i[2:0]};
         step();
         if (i == 254) check("wrap_255", count_VC0, 8'd255);
         if (i == 255) check("wrap_0",   count_VC0, 8'd0);
         if (i == 256) check("wrap_1",   count_VC0, 8'd1);
      end

      // Reset while a VC1 word is parked.
      valid_in = 1'b1; data_in = 4'hB; full_VC1 = 1'b1;
      step();
      check("hold_pending", pending, 1);
      valid_in = 1'b0;
      step();
      #2;
      reset_L = 1'b0;
      model_clear();
      #1;
      check("arst_pending", pending,   0);
      check("arst_count1",  count_VC1, 0);
      check("arst_count0",  count_VC0, 0);
      check("arst_ready",   ready_out, 0);
      step();
      reset_L = 1'b1; full_VC1 = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         check("lost_no_push1", push_VC1, 0);
      end

      // Random traffic; upstream holds its word while the model says not ready.
      for (int i = 0; i < 3000; i++) begin
         if (!(valid_in && !m_rdy)) begin
            valid_in = ($urandom_range(0, 3) != 0);
            data_in  = DW'($urandom);
         end
         full_VC0 = ($urandom_range(0, 9) < 3);
         full_VC1 = ($urandom_range(0, 9) < 3);
         reset_L  = ($urandom_range(0, 299) != 0);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
